// File: rtl/regfile_pkg.sv
// Shared defaults and word/index types for the decode-stage register file
// and its pending scoreboard.
package regfile_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int NUM_READ_MAX   = 4;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_bypass_sb_pend_scoreboard.sv
// Per-register pending bits: decode marks a destination as pending and a
// writeback to that index clears it; a same-edge set beats the clear.
module pend_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_pend_en,
    input  logic [ADDR_WIDTH-1:0]      set_pend_addr,
    input  logic                       wr_en0,
    input  logic [ADDR_WIDTH-1:0]      wr_addr0,
    input  logic                       wr_en1,
    input  logic [ADDR_WIDTH-1:0]      wr_addr1,
    output logic [(2**ADDR_WIDTH)-1:0] pend_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Next-state pending vector; register 0 is never marked when hardwired.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (set_pend_en && (set_pend_addr == ADDR_WIDTH'(i)) && !(ZERO_REG && (i == 0))) begin
                pend_d[i] = 1'b1;
            end else if ((wr_en0 && (wr_addr0 == ADDR_WIDTH'(i))) ||
                         (wr_en1 && (wr_addr1 == ADDR_WIDTH'(i)))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Pending state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= {DEPTH{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file: two writeback ports, NUM_READ combinational
// read ports with optional same-cycle bypass, and a RAW pending scoreboard.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en0,
    input  logic [ADDR_WIDTH-1:0]          wr_addr0,
    input  logic [DATA_WIDTH-1:0]          wr_data0,
    input  logic                           wr_en1,
    input  logic [ADDR_WIDTH-1:0]          wr_addr1,
    input  logic [DATA_WIDTH-1:0]          wr_data1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_pending,
    input  logic                           set_pend_en,
    input  logic [ADDR_WIDTH-1:0]          set_pend_addr,
    output logic                           wr_conflict
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam bit BYP   = (BYPASS != 0);
    localparam bit ZR    = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] IDX0 = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_conflict_q;
    logic                  wr_conflict_d;
    logic                  we0_s;
    logic                  we1_s;
    logic [DEPTH-1:0]      pend_s;

    if ((NUM_READ < 1) || (NUM_READ > NUM_READ_MAX)) begin : g_bad_num_read
        $error("regfile_bypass_sb: NUM_READ must be within 1..NUM_READ_MAX");
    end

    // Writes to a hardwired register 0 are dropped before they reach storage or conflict detection.
    assign we0_s         = wr_en0 && !(ZR && (wr_addr0 == IDX0));
    assign we1_s         = wr_en1 && !(ZR && (wr_addr1 == IDX0));
    assign wr_conflict_d = we0_s && we1_s && (wr_addr0 == wr_addr1);

    // Register storage; port 1 is written last so it wins on a shared index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_conflict_q <= 1'b0;
        end else begin
            if (we0_s) begin
                mem_q[wr_addr0] <= wr_data0;
            end
            if (we1_s) begin
                mem_q[wr_addr1] <= wr_data1;
            end
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    pend_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZR)
    ) u_pend_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_pend_en   (set_pend_en),
        .set_pend_addr (set_pend_addr),
        .wr_en0        (wr_en0),
        .wr_addr0      (wr_addr0),
        .wr_en1        (wr_en1),
        .wr_addr1      (wr_addr1),
        .pend_o        (pend_s)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] rdata_s;
        logic                  rpend_s;
        logic                  clr_hit_s;

        assign ra_s      = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign clr_hit_s = (wr_en0 && (wr_addr0 == ra_s)) || (wr_en1 && (wr_addr1 == ra_s));

        // Read mux: hardwired zero, then port-1 bypass, port-0 bypass, storage.
        always_comb begin
            if (ZR && (ra_s == IDX0)) begin
                rdata_s = {DATA_WIDTH{1'b0}};
            end else if (BYP && !rst && we1_s && (wr_addr1 == ra_s)) begin
                rdata_s = wr_data1;
            end else if (BYP && !rst && we0_s && (wr_addr0 == ra_s)) begin
                rdata_s = wr_data0;
            end else begin
                rdata_s = mem_q[ra_s];
            end
        end

        // A clearing write this cycle hides the pending bit because its data is forwarded.
        always_comb begin
            if (BYP && clr_hit_s) begin
                rpend_s = 1'b0;
            end else begin
                rpend_s = pend_s[ra_s];
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rdata_s;
        assign rd_pending[k]                       = rpend_s;
    end
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the decode-stage register file.
- Adds an asynchronous reset, two write ports (ALU writeback and memory writeback), NUM_READ combinational read ports and optional write-to-read bypass.
- Adds a per-register pending scoreboard so decode can detect RAW hazards.
- Sits in the decode stage between the hazard unit and the ID/EX pipeline register.

Parameters:
- DATA_WIDTH, 16, register width in bits.
- ADDR_WIDTH, 3, register index width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never pending.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en0  in  1  write enable, port 0 (ALU writeback).
- wr_addr0  in  ADDR_WIDTH  write index, port 0.
- wr_data0  in  DATA_WIDTH  write data, port 0.
- wr_en1  in  1  write enable, port 1 (memory writeback).
- wr_addr1  in  ADDR_WIDTH  write index, port 1.
- wr_data1  in  DATA_WIDTH  write data, port 1.
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read indices; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing.
- rd_pending  out  NUM_READ  bit k = 1 when port k's register has an outstanding producer.
- set_pend_en  in  1  decode issues an instruction with a destination register.
- set_pend_addr  in  ADDR_WIDTH  destination index to mark pending.
- wr_conflict  out  1  registered one-cycle pulse: both write ports hit the same address.

Behaviour:
- Reset (async, rst=1): every register = 0, every pending bit = 0, wr_conflict = 0. While rst=1, writes and set_pend are ignored, bypass is suppressed, all rd_data = 0 and all rd_pending = 0.
- Write: on posedge clk with wr_enN=1, reg[wr_addrN] <= wr_dataN.
- Dual-write same address: port 1 wins. wr_conflict = 1 on the following cycle only.
- Read: combinational, zero latency. rd_data[k] = reg[rd_addr[k]].
- Bypass (BYPASS=1): if wr_enN=1 and wr_addrN == rd_addr[k], rd_data[k] = wr_dataN in the same cycle. Port 1 takes precedence when both match.
- BYPASS=0: rd_data shows the new value one cycle after the write edge.
- ZERO_REG=1:
  - index 0 always reads 0, with no bypass.
  - writes to index 0 are discarded and do not raise wr_conflict.
  - set_pend to index 0 is ignored.
- Scoreboard: one pending bit per register.
  - Set on posedge when set_pend_en=1.
  - Cleared on posedge by any wr_enN=1 with a matching address.
  - Simultaneous set and clear on the same index: set wins, so the bit stays 1 (new producer).
- rd_pending[k] = pend[rd_addr[k]], combinational. When BYPASS=1, it is masked to 0 if a write that clears that index is active this cycle (data is available via bypass).
- Reset asserted mid-operation clears state immediately, regardless of clk.
- Out-of-range NUM_READ is an elaboration error (generate-time check).

Decomposition:
- Package regfile_pkg:
  - DATA_WIDTH_DEF, ADDR_WIDTH_DEF, NUM_READ_MAX.
  - typedef reg_idx_t (ADDR_WIDTH bits) and word_t (DATA_WIDTH bits).
- Sub-module pend_scoreboard:
  - inputs: clk, rst, set_pend_en, set_pend_addr, and both write enables and addresses.
  - output: the pending vector.
  - instantiated once.
- Read ports, bypass muxing and the zero-register mask are handled in a generate loop in the top module.

Test Plan:
- Reset: write 0xBEEF to r3, pulse rst mid-cycle -> rd_data for r3 = 0x0000 immediately; wr_conflict = 0; all rd_pending = 0.
- Bypass: wr_en0=1, addr 5, data 0x1234; rd_addr[0]=5 in the same cycle -> rd_data[0] = 0x1234 before the edge (BYPASS=1). With BYPASS=0 -> old value, then 0x1234 after the edge.
- Dual write: wr0 r2=0x1111 and wr1 r2=0x2222 -> r2 reads 0x2222; wr_conflict = 1 for exactly one cycle; bypass reads also give 0x2222.
- Scoreboard:
  - set_pend r4 -> rd_pending = 1 for a port reading r4 on the next cycle.
  - wr_en1 r4 = 0x00AA -> same cycle: rd_pending = 0 and rd_data = 0x00AA (bypass).
  - Set and clear of r4 in the same cycle -> pending stays 1.
- ZERO_REG=1: write 0xFFFF to r0 and set_pend r0 -> r0 reads 0x0000, rd_pending = 0, no wr_conflict on dual r0 write.
- NUM_READ=4: four distinct addresses after writing r1..r7 = 0x0011..0x0077 -> each port returns its correct packed slice.
